readout_scheduler: RTL
======================

Name: readout_scheduler

Overview:
- Ping-pong buffer scheduler that sequences the 4-lane row read streamer against the frame writer and the decision engine.
- Tracks which of two memory-bank buffers is full and hands the writer a free buffer.
- When a full buffer exists and the decision engine is ready, issues a single start pulse to the streamer.
- Checks the returned beat stream (count and base IDs), waits for decision completion, releases the buffer, and flags overrun, sequence and timeout errors.

Parameters:
- BEAT_COUNT, default ROWS_PER_BANK (25): number of valid beats per frame.
- TIMEOUT_CYCLES, default 64: maximum number of cycles without progress in STREAM or WAIT_DONE.
- FRAME_CNT_W, default 16: width of the completed-frame counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_frame_done  in  1  pulse; the writer finished filling buffer o_wr_buf_sel.
- o_wr_buf_sel  out  1  buffer the writer fills.
- o_wr_allow  out  1  writer may write; equals ~full[o_wr_buf_sel].
- o_rd_buf_sel  out  1  buffer the streamer reads; drives the bank-address MSB.
- o_stream_start  out  1  one-cycle start pulse to the streamer.
- i_lane_valid  in  1  streamer output valid.
- i_lane_base_id  in  QUBIT_ID_WIDTH  streamer batch base ID.
- i_decision_ready  in  1  decision engine can accept a frame.
- i_decision_done  in  1  pulse; decision engine finished the frame.
- i_clear_err  in  1  clears all sticky errors.
- o_busy  out  1  FSM is not IDLE.
- o_frame_cnt  out  FRAME_CNT_W  frames released; wraps modulo 2^FRAME_CNT_W.
- o_err_overrun  out  1  sticky.
- o_err_seq  out  1  sticky.
- o_err_timeout  out  1  sticky.

Behaviour:
- Reset: all outputs 0, full[1:0]=0, wr_sel=0, rd_sel=0, FSM=IDLE, beat_cnt=0, timer=0.
- Writer side, evaluated on pre-cycle full state:
  - i_frame_done with full[wr_sel]=0: set full[wr_sel], toggle wr_sel.
  - i_frame_done with full[wr_sel]=1: set err_overrun; no state change; frame dropped.
  - A release of the same buffer in the same cycle does not prevent the overrun.
- FSM states: IDLE, START, STREAM, WAIT_DONE, RELEASE.
  - IDLE -> START when full[rd_sel] && i_decision_ready.
  - START: o_stream_start=1 for exactly this cycle; clear beat_cnt and timer; go to STREAM.
  - STREAM: each i_lane_valid increments beat_cnt and clears the timer.
    - Expected i_lane_base_id = beat_cnt*NUM_BANKS; a mismatch sets err_seq and the beat is still counted.
    - After beat BEAT_COUNT is counted, go to WAIT_DONE.
    - The first beat arrives 3 cycles after o_stream_start.
  - WAIT_DONE -> RELEASE on i_decision_done.
    - i_lane_valid here sets err_seq.
    - i_decision_done in the same cycle as the last beat is also accepted.
  - RELEASE (1 cycle): clear full[rd_sel], toggle rd_sel, o_frame_cnt+1, go to IDLE.
- Timeout:
  - The timer runs in STREAM and WAIT_DONE and resets on any progress.
  - When timer==TIMEOUT_CYCLES: set err_timeout, go to RELEASE (frame dropped, still counted).
- Outside STREAM:
  - i_lane_valid in IDLE, START or RELEASE sets err_seq.
  - i_decision_done outside WAIT_DONE is ignored.
- Error flags:
  - Sticky until i_clear_err.
  - If i_clear_err and a new error event occur in the same cycle, the flag ends set.
- o_busy = (state != IDLE), registered.
- Reset mid-frame: everything returns to reset values. The streamer is reset by the same reset.

Optional Feature:
- Macro READOUT_SCHED_PERF_EN.
- Defined:
  - Adds output o_stall_cycles (32 bits, saturating).
  - Counts cycles in IDLE with full[rd_sel]=1 and i_decision_ready=0.
  - Resets to 0; cleared by i_clear_err.
- Undefined: the port and the counter do not exist.

Decomposition:
- Shared package qc_params_pkg holds:
  - the existing constants ROWS_PER_BANK, NUM_BANKS, QUBIT_ID_WIDTH, ROW_COUNT_WIDTH;
  - the new typedef sched_state_e (IDLE, START, STREAM, WAIT_DONE, RELEASE).
- One sub-module: pingpong_buf_tracker, owning full[1:0], wr_sel, rd_sel and overrun detection.
- The FSM and checker stay in the top level.

Test Plan:
- Single frame: i_frame_done, decision_ready=1; streamer model returns 25 beats with IDs 0,4..96, then done.
  - start pulses once; o_frame_cnt=1; rd_sel=1; wr_sel=1; no errors.
- Back-to-back: two i_frame_done 5 cycles apart; third i_frame_done before any release.
  - o_wr_allow=0 after the second; err_overrun=1 on the third; both frames complete; frame_cnt=2.
- Beat 7 returns base_id 0x20 instead of 0x1C.
  - err_seq=1; frame completes normally; i_clear_err clears it.
- Streamer stops after 10 beats.
  - err_timeout set 64 cycles after beat 10; RELEASE occurs; buffer is freed.
- decision_ready held 0 for 40 cycles with a full buffer.
  - No start pulse during that time; start pulse the cycle after ready rises; with READOUT_SCHED_PERF_EN, o_stall_cycles=40.
- Assert i_rst during STREAM at beat 12.
  - All outputs 0 next cycle; a subsequent frame runs cleanly.

Source files
------------

// File: rtl/qc_params_pkg.sv
// Shared readout constants and the scheduler state encoding.
// Expected streamer base IDs are derived here so that every consumer agrees on them.
package qc_params_pkg;

  localparam int unsigned ROWS_PER_BANK   = 32'd25;
  localparam int unsigned NUM_BANKS       = 32'd4;
  localparam int unsigned QUBIT_ID_WIDTH  = 32'd7;
  localparam int unsigned ROW_COUNT_WIDTH = 32'd5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    STREAM    = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } sched_state_e;

  // Each streamer batch covers one row across all banks.
  function automatic logic [QUBIT_ID_WIDTH-1:0] expected_base_id(input logic [31:0] beat);
    return QUBIT_ID_WIDTH'(beat * NUM_BANKS);
  endfunction

endpackage

// File: rtl/pingpong_buf_tracker.sv
// Two-entry ping-pong occupancy tracker: owns full[1:0], writer and reader selects,
// and flags a writer frame that lands on a buffer that is still full.
module pingpong_buf_tracker (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_done,
  input  logic       i_release,
  output logic [1:0] o_full,
  output logic       o_wr_sel,
  output logic       o_rd_sel,
  output logic       o_wr_allow,
  output logic       o_overrun
);

  logic [1:0] r_full;
  logic       r_wr_sel;
  logic       r_rd_sel;
  logic       r_wr_allow;
  logic [1:0] w_full_nxt;
  logic       w_wr_sel_nxt;
  logic       w_rd_sel_nxt;
  logic       w_overrun;

  // Writer decision uses pre-cycle occupancy, so a same-cycle release cannot mask an overrun.
  always_comb begin
    w_full_nxt   = r_full;
    w_wr_sel_nxt = r_wr_sel;
    w_rd_sel_nxt = r_rd_sel;
    w_overrun    = 1'b0;
    if (i_frame_done) begin
      if (r_full[r_wr_sel]) begin
        w_overrun = 1'b1;
      end else begin
        w_full_nxt[r_wr_sel] = 1'b1;
        w_wr_sel_nxt         = ~r_wr_sel;
      end
    end else begin
      w_overrun = 1'b0;
    end
    if (i_release) begin
      w_full_nxt[r_rd_sel] = 1'b0;
      w_rd_sel_nxt         = ~r_rd_sel;
    end else begin
      w_rd_sel_nxt = r_rd_sel;
    end
  end

  // Occupancy state; wr_allow is precomputed from next state so it stays registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full     <= 2'b00;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_wr_allow <= 1'b0;
    end else begin
      r_full     <= w_full_nxt;
      r_wr_sel   <= w_wr_sel_nxt;
      r_rd_sel   <= w_rd_sel_nxt;
      r_wr_allow <= ~w_full_nxt[w_wr_sel_nxt];
    end
  end

  assign o_full     = r_full;
  assign o_wr_sel   = r_wr_sel;
  assign o_rd_sel   = r_rd_sel;
  assign o_wr_allow = r_wr_allow;
  assign o_overrun  = w_overrun;

endmodule

// File: rtl/readout_scheduler.sv
// Ping-pong readout scheduler: starts the row streamer, checks its beats, releases buffers.
// Optional stall counter output o_stall_cycles is built when READOUT_SCHED_PERF_EN is defined.
module readout_scheduler
  import qc_params_pkg::*;
#(
  parameter int unsigned BEAT_COUNT     = ROWS_PER_BANK,
  parameter int unsigned TIMEOUT_CYCLES = 32'd64,
  parameter int unsigned FRAME_CNT_W    = 32'd16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_frame_done,
  output logic                      o_wr_buf_sel,
  output logic                      o_wr_allow,
  output logic                      o_rd_buf_sel,
  output logic                      o_stream_start,
  input  logic                      i_lane_valid,
  input  logic [QUBIT_ID_WIDTH-1:0] i_lane_base_id,
  input  logic                      i_decision_ready,
  input  logic                      i_decision_done,
  input  logic                      i_clear_err,
  output logic                      o_busy,
  output logic [FRAME_CNT_W-1:0]    o_frame_cnt,
  output logic                      o_err_overrun,
  output logic                      o_err_seq,
  output logic                      o_err_timeout
`ifdef READOUT_SCHED_PERF_EN
  ,
  output logic [31:0]               o_stall_cycles
`endif
);

  localparam int unsigned BEAT_W  = $clog2(BEAT_COUNT + 32'd1);
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 32'd1);

  sched_state_e           r_state;
  sched_state_e           w_state_nxt;
  logic [BEAT_W-1:0]      r_beat_cnt;
  logic [BEAT_W-1:0]      w_beat_cnt_nxt;
  logic [TIMER_W-1:0]     r_timer;
  logic [TIMER_W-1:0]     w_timer_nxt;
  logic                   r_stream_start;
  logic                   r_busy;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   r_err_overrun;
  logic                   r_err_seq;
  logic                   r_err_timeout;
  logic                   w_release;
  logic                   w_seq_evt;
  logic                   w_timeout_evt;
  logic [1:0]             w_full;
  logic                   w_rd_sel;
  logic                   w_overrun;

  pingpong_buf_tracker u_tracker (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_frame_done(i_frame_done),
    .i_release   (w_release),
    .o_full      (w_full),
    .o_wr_sel    (o_wr_buf_sel),
    .o_rd_sel    (w_rd_sel),
    .o_wr_allow  (o_wr_allow),
    .o_overrun   (w_overrun)
  );

  // Next-state, beat/timer bookkeeping and error events.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_timer_nxt    = r_timer;
    w_release      = 1'b0;
    w_seq_evt      = 1'b0;
    w_timeout_evt  = 1'b0;
    if (i_lane_valid) begin
      if (r_state != STREAM) begin
        w_seq_evt = 1'b1;
      end else begin
        w_seq_evt = (i_lane_base_id != expected_base_id(32'(r_beat_cnt)));
      end
    end else begin
      w_seq_evt = 1'b0;
    end
    case (r_state)
      IDLE: begin
        if (w_full[w_rd_sel] && i_decision_ready) begin
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        w_beat_cnt_nxt = '0;
        w_timer_nxt    = '0;
        w_state_nxt    = STREAM;
      end
      STREAM: begin
        if (i_lane_valid) begin
          w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
          w_timer_nxt    = '0;
          if (w_beat_cnt_nxt == BEAT_W'(BEAT_COUNT)) begin
            // A decision that completes alongside the last beat is honoured.
            w_state_nxt = i_decision_done ? RELEASE : WAIT_DONE;
          end else begin
            w_state_nxt = STREAM;
          end
        end else if (r_timer == TIMER_W'(TIMEOUT_CYCLES)) begin
          w_timeout_evt = 1'b1;
          w_state_nxt   = RELEASE;
        end else begin
          w_timer_nxt = r_timer + TIMER_W'(1);
        end
      end
      WAIT_DONE: begin
        if (i_decision_done) begin
          w_state_nxt = RELEASE;
        end else if (r_timer == TIMER_W'(TIMEOUT_CYCLES)) begin
          w_timeout_evt = 1'b1;
          w_state_nxt   = RELEASE;
        end else begin
          w_timer_nxt = r_timer + TIMER_W'(1);
        end
      end
      RELEASE: begin
        w_release   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register, registered outputs and sticky error flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_beat_cnt     <= '0;
      r_timer        <= '0;
      r_stream_start <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_cnt    <= '0;
      r_err_overrun  <= 1'b0;
      r_err_seq      <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_beat_cnt     <= w_beat_cnt_nxt;
      r_timer        <= w_timer_nxt;
      r_stream_start <= (w_state_nxt == START);
      r_busy         <= (w_state_nxt != IDLE);
      r_frame_cnt    <= w_release ? (r_frame_cnt + FRAME_CNT_W'(1)) : r_frame_cnt;
      r_err_overrun  <= (r_err_overrun && !i_clear_err) || w_overrun;
      r_err_seq      <= (r_err_seq && !i_clear_err) || w_seq_evt;
      r_err_timeout  <= (r_err_timeout && !i_clear_err) || w_timeout_evt;
    end
  end

`ifdef READOUT_SCHED_PERF_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of cycles where a full buffer waits on the decision engine.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= 32'd0;
    end else if (i_clear_err) begin
      r_stall_cycles <= 32'd0;
    end else if ((r_state == IDLE) && w_full[w_rd_sel] && !i_decision_ready &&
                 (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

  assign o_rd_buf_sel   = w_rd_sel;
  assign o_stream_start = r_stream_start;
  assign o_busy         = r_busy;
  assign o_frame_cnt    = r_frame_cnt;
  assign o_err_overrun  = r_err_overrun;
  assign o_err_seq      = r_err_seq;
  assign o_err_timeout  = r_err_timeout;

endmodule
